// File: rtl/cpu_ctrl_fsm_gen2.sv
// cpu_ctrl_fsm_gen2: fetch/decode/execute sequencer for the 8-op RISC CPU.
// Multi-word fetch, mem_ready handshake with timeout, resumable halt.
module cpu_ctrl_fsm_gen2 #(
  parameter int OPW         = 3,
  parameter int FETCH_WORDS = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  input  logic           resume,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_acc,
  output logic           load_ir,
  output logic           rd,
  output logic           wr,
  output logic           datactl_enable,
  output logic           halt,
  output logic           bus_err,
  output logic [3:0]     state_dbg
);

  localparam int IW = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FETCH_WORDS - 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_OPRD   = 4'd3,
    S_ACC    = 4'd4,
    S_WSETUP = 4'd5,
    S_WRITE  = 4'd6,
    S_JUMP   = 4'd7,
    S_SKIP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic dctl;
    logic halt;
  } out_t;

  localparam out_t O_NONE  = 8'b0000_0000;
  localparam out_t O_FETCH = 8'b0001_1000;
  localparam out_t O_INC   = 8'b1000_0000;
  localparam out_t O_RD    = 8'b0000_1000;
  localparam out_t O_ACC   = 8'b0010_1000;
  localparam out_t O_WSET  = 8'b0000_0010;
  localparam out_t O_WRITE = 8'b0000_0110;
  localparam out_t O_JUMP  = 8'b0100_0000;
  localparam out_t O_HALT  = 8'b0000_0001;

  state_t        r_state;
  out_t          r_o;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_skip;
  logic [WW-1:0] r_wait;
  logic          r_bus_err;

  state_t        w_nxt_state;
  out_t          w_nxt_o;
  logic [IW-1:0] w_nxt_idx;
  logic [IW-1:0] w_nxt_skip;
  logic [WW-1:0] w_nxt_wait;
  logic          w_nxt_berr;

  logic [OPW-1:0] w_hi;
  logic [2:0]     w_op;
  logic           w_legacy;
  logic           w_hlt;
  logic           w_alu;
  logic           w_sta;
  logic           w_jmp;
  logic           w_skip;
  logic           w_tmo;

  // opcode classes; codes with upper bits set fall through as NOP
  always_comb begin
    w_hi     = opcode >> 3;
    w_op     = opcode[2:0];
    w_legacy = (w_hi == '0);
    w_hlt    = w_legacy && (w_op == 3'd0);
    w_alu    = w_legacy && (w_op >= 3'd2) && (w_op <= 3'd5);
    w_sta    = w_legacy && (w_op == 3'd6);
    w_jmp    = w_legacy && (w_op == 3'd7);
    w_skip   = w_legacy && (w_op == 3'd1) && zero;
    w_tmo    = (MAX_WAIT > 0) && (r_wait == WAIT_LIM);
  end

  // next state and next registered outputs for the state being entered
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_o     = O_NONE;
    w_nxt_idx   = r_idx;
    w_nxt_skip  = r_skip;
    w_nxt_wait  = '0;
    w_nxt_berr  = r_bus_err;
    if (!enable) begin
      w_nxt_state = S_IDLE;
      w_nxt_idx   = '0;
      w_nxt_skip  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_state = S_FETCH;
          w_nxt_o     = O_FETCH;
          w_nxt_idx   = '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            if (r_idx == LAST_IDX) begin
              w_nxt_state = S_DECODE;
              w_nxt_o     = O_INC;
              w_nxt_idx   = '0;
            end else begin
              w_nxt_o        = O_FETCH;
              w_nxt_o.inc_pc = 1'b1;
              w_nxt_idx      = r_idx + IW'(1);
            end
          end else if (w_tmo) begin
            w_nxt_state = S_HALT;
            w_nxt_o     = O_HALT;
            w_nxt_berr  = 1'b1;
          end else begin
            w_nxt_o    = O_FETCH;
            w_nxt_wait = r_wait + WW'(1);
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            w_hlt: begin
              w_nxt_state = S_HALT;
              w_nxt_o     = O_HALT;
            end
            w_alu: begin
              w_nxt_state = S_OPRD;
              w_nxt_o     = O_RD;
            end
            w_sta: begin
              w_nxt_state = S_WSETUP;
              w_nxt_o     = O_WSET;
            end
            w_jmp: begin
              w_nxt_state = S_JUMP;
              w_nxt_o     = O_JUMP;
            end
            w_skip: begin
              w_nxt_state = S_SKIP;
              w_nxt_o     = O_INC;
              w_nxt_skip  = LAST_IDX;
            end
            default: begin
              w_nxt_state = S_FETCH;
              w_nxt_o     = O_FETCH;
              w_nxt_idx   = '0;
            end
          endcase
        end
        S_OPRD: begin
          if (mem_ready) begin
            w_nxt_state = S_ACC;
            w_nxt_o     = O_ACC;
          end else if (w_tmo) begin
            w_nxt_state = S_HALT;
            w_nxt_o     = O_HALT;
            w_nxt_berr  = 1'b1;
          end else begin
            w_nxt_o    = O_RD;
            w_nxt_wait = r_wait + WW'(1);
          end
        end
        S_ACC, S_JUMP: begin
          w_nxt_state = S_FETCH;
          w_nxt_o     = O_FETCH;
          w_nxt_idx   = '0;
        end
        S_WSETUP: begin
          w_nxt_state = S_WRITE;
          w_nxt_o     = O_WRITE;
        end
        S_WRITE: begin
          if (mem_ready) begin
            w_nxt_state = S_FETCH;
            w_nxt_o     = O_FETCH;
            w_nxt_idx   = '0;
          end else if (w_tmo) begin
            w_nxt_state = S_HALT;
            w_nxt_o     = O_HALT;
            w_nxt_berr  = 1'b1;
          end else begin
            w_nxt_o    = O_WRITE;
            w_nxt_wait = r_wait + WW'(1);
          end
        end
        S_SKIP: begin
          if (r_skip != '0) begin
            w_nxt_o    = O_INC;
            w_nxt_skip = r_skip - IW'(1);
          end else begin
            w_nxt_state = S_FETCH;
            w_nxt_o     = O_FETCH;
            w_nxt_idx   = '0;
          end
        end
        S_HALT: begin
          if (resume && !r_bus_err) begin
            w_nxt_state = S_FETCH;
            w_nxt_o     = O_FETCH;
            w_nxt_idx   = '0;
          end else begin
            w_nxt_o = O_HALT;
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_idx   = '0;
          w_nxt_skip  = '0;
        end
      endcase
    end
  end

  // state, counters and outputs all advance on the falling edge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_o       <= O_NONE;
      r_idx     <= '0;
      r_skip    <= '0;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_o       <= w_nxt_o;
      r_idx     <= w_nxt_idx;
      r_skip    <= w_nxt_skip;
      r_wait    <= w_nxt_wait;
      r_bus_err <= w_nxt_berr;
    end
  end

  assign inc_pc         = r_o.inc_pc;
  assign load_pc        = r_o.load_pc;
  assign load_acc       = r_o.load_acc;
  assign load_ir        = r_o.load_ir;
  assign rd             = r_o.rd;
  assign wr             = r_o.wr;
  assign datactl_enable = r_o.dctl;
  assign halt           = r_o.halt;
  assign bus_err        = r_bus_err;
  assign state_dbg      = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm_gen2.sv
// tb_cpu_ctrl_fsm_gen2: directed vectors with a scoreboard queue.
// Stimulus pushes the expected post-edge state; a monitor pops and compares.
module tb_cpu_ctrl_fsm_gen2;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       resume;
  logic       inc_pc;
  logic       load_pc;
  logic       load_acc;
  logic       load_ir;
  logic       rd;
  logic       wr;
  logic       datactl_enable;
  logic       halt;
  logic       bus_err;
  logic [3:0] state_dbg;

  cpu_ctrl_fsm_gen2 #(
    .OPW(3),
    .FETCH_WORDS(2),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .resume(resume),
    .inc_pc(inc_pc),
    .load_pc(load_pc),
    .load_acc(load_acc),
    .load_ir(load_ir),
    .rd(rd),
    .wr(wr),
    .datactl_enable(datactl_enable),
    .halt(halt),
    .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  // {inc_pc, load_pc, load_acc, load_ir, rd, wr, dctl, halt, bus_err}
  localparam logic [8:0] O_N  = 9'b000000000;
  localparam logic [8:0] O_F  = 9'b000110000;
  localparam logic [8:0] O_FI = 9'b100110000;
  localparam logic [8:0] O_DI = 9'b100000000;
  localparam logic [8:0] O_OR = 9'b000010000;
  localparam logic [8:0] O_AC = 9'b001010000;
  localparam logic [8:0] O_WS = 9'b000000100;
  localparam logic [8:0] O_WR = 9'b000001100;
  localparam logic [8:0] O_JP = 9'b010000000;
  localparam logic [8:0] O_SK = 9'b100000000;
  localparam logic [8:0] O_H  = 9'b000000010;
  localparam logic [8:0] O_HB = 9'b000000011;

  typedef struct {
    logic [3:0] st;
    logic [8:0] o;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [12:0] act;
  assign act = {state_dbg, inc_pc, load_pc, load_acc, load_ir,
                rd, wr, datactl_enable, halt, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [12:0] a,
                     input logic [12:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got st=%0d o=%b, want st=%0d o=%b",
               nm, a[12:9], a[8:0], e[12:9], e[8:0]);
    end
  endtask

  task automatic cyc(input logic en, input logic [2:0] op,
                     input logic z, input logic rdy, input logic res,
                     input logic [3:0] st, input logic [8:0] o,
                     input string nm);
    exp_t e;
    @(posedge clk);
    enable    = en;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    resume    = res;
    e.st = st;
    e.o  = o;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic rst_async(input string nm);
    @(negedge clk);
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    chk(nm, act, 13'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor: compare after every falling edge with a pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, act, {e.st, e.o});
        n_checks++;
        if ((rd && wr) || (load_pc && inc_pc)) begin
          n_errors++;
          $display("FAIL %s_excl: rd=%b wr=%b load_pc=%b inc_pc=%b",
                   e.nm, rd, wr, load_pc, inc_pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; opcode = '0;
    zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", act, 13'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LDA, ready tied high
    cyc(1, 5, 0, 1, 0, 4'd1, O_F,  "lda_f0");
    cyc(1, 5, 0, 1, 0, 4'd1, O_FI, "lda_f1");
    cyc(1, 5, 0, 1, 0, 4'd2, O_DI, "lda_dec");
    cyc(1, 5, 0, 1, 0, 4'd3, O_OR, "lda_oprd");
    cyc(1, 5, 0, 1, 0, 4'd4, O_AC, "lda_acc");
    cyc(1, 5, 0, 1, 0, 4'd1, O_F,  "lda_fetch");
    // STA, ready low for 3 WRITE edges
    cyc(1, 6, 0, 1, 0, 4'd1, O_FI, "sta_f1");
    cyc(1, 6, 0, 1, 0, 4'd2, O_DI, "sta_dec");
    cyc(1, 6, 0, 0, 0, 4'd5, O_WS, "sta_wsetup");
    cyc(1, 6, 0, 0, 0, 4'd6, O_WR, "sta_wr0");
    cyc(1, 6, 0, 0, 0, 4'd6, O_WR, "sta_wr1");
    cyc(1, 6, 0, 0, 0, 4'd6, O_WR, "sta_wr2");
    cyc(1, 6, 0, 0, 0, 4'd6, O_WR, "sta_wr3");
    cyc(1, 6, 0, 1, 0, 4'd1, O_F,  "sta_done");
    // SKZ taken
    cyc(1, 1, 1, 1, 0, 4'd1, O_FI, "skz1_f1");
    cyc(1, 1, 1, 1, 0, 4'd2, O_DI, "skz1_dec");
    cyc(1, 1, 1, 1, 0, 4'd8, O_SK, "skz1_skip0");
    cyc(1, 1, 1, 1, 0, 4'd8, O_SK, "skz1_skip1");
    cyc(1, 1, 1, 1, 0, 4'd1, O_F,  "skz1_fetch");
    // SKZ not taken
    cyc(1, 1, 0, 1, 0, 4'd1, O_FI, "skz0_f1");
    cyc(1, 1, 0, 1, 0, 4'd2, O_DI, "skz0_dec");
    cyc(1, 1, 0, 1, 0, 4'd1, O_F,  "skz0_fetch");
    // HLT then resume
    cyc(1, 0, 0, 1, 0, 4'd1, O_FI, "hlt_f1");
    cyc(1, 0, 0, 1, 0, 4'd2, O_DI, "hlt_dec");
    cyc(1, 0, 0, 1, 0, 4'd9, O_H,  "hlt_enter");
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 1, 0, 4'd9, O_H, "hlt_hold");
    cyc(1, 0, 0, 1, 1, 4'd1, O_F,  "hlt_resume");
    // JMP; first fetch edge also proves idx restarted at 0
    cyc(1, 7, 0, 1, 0, 4'd1, O_FI, "jmp_f1");
    cyc(1, 7, 0, 1, 0, 4'd2, O_DI, "jmp_dec");
    cyc(1, 7, 0, 1, 0, 4'd7, O_JP, "jmp_jump");
    cyc(1, 7, 0, 1, 0, 4'd1, O_F,  "jmp_fetch");
    // ADD aborted by enable=0 in OPRD
    cyc(1, 2, 0, 1, 0, 4'd1, O_FI, "add_f1");
    cyc(1, 2, 0, 1, 0, 4'd2, O_DI, "add_dec");
    cyc(1, 2, 0, 1, 0, 4'd3, O_OR, "add_oprd");
    cyc(0, 2, 0, 0, 0, 4'd0, O_N,  "en_off_idle");
    cyc(0, 2, 0, 1, 0, 4'd0, O_N,  "en_off_hold");
    cyc(1, 2, 0, 1, 0, 4'd1, O_F,  "en_on_fetch");
    // fetch timeout after 4 waiting edges
    cyc(1, 2, 0, 0, 0, 4'd1, O_F,  "tmo_w1");
    cyc(1, 2, 0, 0, 0, 4'd1, O_F,  "tmo_w2");
    cyc(1, 2, 0, 0, 0, 4'd1, O_F,  "tmo_w3");
    cyc(1, 2, 0, 0, 0, 4'd9, O_HB, "tmo_halt");
    cyc(1, 2, 0, 0, 1, 4'd9, O_HB, "tmo_res_ign0");
    cyc(1, 2, 0, 1, 1, 4'd9, O_HB, "tmo_res_ign1");
    rst_async("rst_clr_berr");
    // ready arriving on the limit edge completes the read
    cyc(1, 2, 0, 1, 0, 4'd1, O_F,  "tie_f0");
    cyc(1, 2, 0, 1, 0, 4'd1, O_FI, "tie_f1");
    cyc(1, 2, 0, 1, 0, 4'd2, O_DI, "tie_dec");
    cyc(1, 2, 0, 1, 0, 4'd3, O_OR, "tie_oprd");
    cyc(1, 2, 0, 0, 0, 4'd3, O_OR, "tie_w1");
    cyc(1, 2, 0, 0, 0, 4'd3, O_OR, "tie_w2");
    cyc(1, 2, 0, 0, 0, 4'd3, O_OR, "tie_w3");
    cyc(1, 2, 0, 1, 0, 4'd4, O_AC, "tie_acc");
    cyc(1, 2, 0, 1, 0, 4'd1, O_F,  "tie_fetch");
    // async reset in the middle of a write
    cyc(1, 6, 0, 1, 0, 4'd1, O_FI, "rw_f1");
    cyc(1, 6, 0, 1, 0, 4'd2, O_DI, "rw_dec");
    cyc(1, 6, 0, 0, 0, 4'd5, O_WS, "rw_wsetup");
    cyc(1, 6, 0, 0, 0, 4'd6, O_WR, "rw_write");
    rst_async("rst_mid_write");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
